int_issue_unit: RTL and testbench

Integer issue/execute unit: the consumer end of the integer issue queue's ready/done handshake and the producer end of the CDB that the queue snoops. It accepts the oldest ready entry presented by the issue queue, executes it (single-cycle ALU or multi-cycle multiply), requests the CDB from the bus arbiter and broadcasts the result tag and data for exactly one cycle.

---
 rtl/int_issue_pkg.sv | 25 ++
 rtl/int_issue_unit_if.sv | 31 +++
 rtl/int_mul_pipe.sv | 40 ++++
 rtl/int_issue_unit.sv | 143 ++++++++++++++
 tb/tb_int_issue_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/int_issue_pkg.sv
// Shared types for the integer issue/execute unit: default widths, opcode and FSM state encodings.
package int_issue_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 6;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_REQ   = 2'd2,
    ST_BCAST = 2'd3
  } state_e;

endpackage

// File: rtl/int_issue_unit_if.sv
// Issue-queue handshake plus CDB request/broadcast bundle; master = queue/arbiter side, slave = issue unit.
interface int_issue_unit_if
  import int_issue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
);

  logic              issueque_ready;
  logic [2:0]        issue_opcode;
  logic [TAG_W-1:0]  issue_rd_tag;
  logic [DATA_W-1:0] issue_rs1_data;
  logic [DATA_W-1:0] issue_rs2_data;
  logic              issueblk_done;
  logic              cdb_req;
  logic              cdb_grant;
  logic              CDB_valid;
  logic [TAG_W-1:0]  CDB_tag;
  logic [DATA_W-1:0] CDB_data;

  modport master (
    output issueque_ready, issue_opcode, issue_rd_tag, issue_rs1_data, issue_rs2_data, cdb_grant,
    input  issueblk_done, cdb_req, CDB_valid, CDB_tag, CDB_data
  );

  modport slave (
    input  issueque_ready, issue_opcode, issue_rd_tag, issue_rs1_data, issue_rs2_data, cdb_grant,
    output issueblk_done, cdb_req, CDB_valid, CDB_tag, CDB_data
  );

endinterface

// File: rtl/int_mul_pipe.sv
// LAT-stage registered unsigned multiplier (low DATA_W bits); o_done asserts LAT cycles after i_start.
// Only built with INT_ISSUE_MUL_EN; no backpressure, the caller never restarts before done.
`ifdef INT_ISSUE_MUL_EN
module int_mul_pipe #(
  parameter int DATA_W = 32,
  parameter int LAT    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_done,
  output logic [DATA_W-1:0] o_res
);

  logic [DATA_W-1:0] r_prod [LAT];
  logic [LAT-1:0]    r_vld;

  always_ff @(posedge clk) begin
    r_prod[0] <= i_a * i_b;
    for (int i = 1; i < LAT; i++) begin
      r_prod[i] <= r_prod[i-1];
    end
  end

  // Only the valid chain needs reset; a flushed product is never reported.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[LAT-2:0], i_start};
    end
  end

  assign o_done = r_vld[LAT-1];
  assign o_res  = r_prod[LAT-1];

endmodule
`endif

// File: rtl/int_issue_unit.sv
// Integer issue/execute: accept from issue queue, 1-cycle ALU or MUL_LAT-cycle MUL (INT_ISSUE_MUL_EN), CDB req/broadcast.
// Accept-to-CDB_valid is 3 cycles (ALU) or MUL_LAT+2 (MUL) plus grant wait; no accepts while in EXEC/REQ.
module int_issue_unit
  import int_issue_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  int_issue_unit_if.slave   io_bus
);

  if (MUL_LAT < 2 || MUL_LAT > 8) begin : g_bad_lat
    $error("int_issue_unit: MUL_LAT must be in 2..8");
  end

  state_e            r_state, w_state_nxt;
  logic              w_accept, w_exec_fin;
  logic              w_cdb_req, w_cdb_vld;
  op_e               r_op;
  logic [TAG_W-1:0]  r_tag, r_cdb_tag;
  logic [DATA_W-1:0] r_rs1, r_rs2, r_res, r_cdb_data;
  logic [DATA_W-1:0] w_alu, w_res;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_cdb_req   = 1'b0;
    w_cdb_vld   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = io_bus.issueque_ready;
        if (w_accept) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_exec_fin) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        w_cdb_req = 1'b1;
        if (io_bus.cdb_grant) w_state_nxt = ST_BCAST;
      end
      ST_BCAST: begin
        w_cdb_vld   = 1'b1;
        w_accept    = io_bus.issueque_ready;
        w_state_nxt = w_accept ? ST_EXEC : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = r_rs1 + r_rs2;
      OP_SUB:  w_alu = r_rs1 - r_rs2;
      OP_AND:  w_alu = r_rs1 & r_rs2;
      OP_OR:   w_alu = r_rs1 | r_rs2;
      OP_XOR:  w_alu = r_rs1 ^ r_rs2;
      OP_SLL:  w_alu = r_rs1 << r_rs2[4:0];
      OP_SRL:  w_alu = r_rs1 >> r_rs2[4:0];
      default: w_alu = '0;
    endcase
  end

`ifdef INT_ISSUE_MUL_EN
  logic [2:0]        r_cnt;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_mul_res;

  // Counter paces EXEC; ALU ops load zero and leave after one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 3'd0;
    end else if (w_accept) begin
      r_cnt <= (op_e'(io_bus.issue_opcode) == OP_MUL) ? 3'(MUL_LAT - 1) : 3'd0;
    end else if (r_state == ST_EXEC && r_cnt != 3'd0) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  int_mul_pipe #(
    .DATA_W (DATA_W),
    .LAT    (MUL_LAT)
  ) u_mul_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept && (op_e'(io_bus.issue_opcode) == OP_MUL)),
    .i_a     (io_bus.issue_rs1_data),
    .i_b     (io_bus.issue_rs2_data),
    .o_done  (w_mul_done),
    .o_res   (w_mul_res)
  );

  assign w_exec_fin = (r_cnt == 3'd0) && ((r_op != OP_MUL) || w_mul_done);
  assign w_res      = (r_op == OP_MUL) ? w_mul_res : w_alu;
`else
  assign w_exec_fin = 1'b1;
  assign w_res      = w_alu;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op       <= OP_ADD;
      r_tag      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_res      <= '0;
      r_cdb_tag  <= '0;
      r_cdb_data <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= op_e'(io_bus.issue_opcode);
        r_tag <= io_bus.issue_rd_tag;
        r_rs1 <= io_bus.issue_rs1_data;
        r_rs2 <= io_bus.issue_rs2_data;
      end
      if (r_state == ST_EXEC && w_exec_fin) begin
        r_res <= w_res;
      end
      if (r_state == ST_REQ && io_bus.cdb_grant) begin
        r_cdb_tag  <= r_tag;
        r_cdb_data <= r_res;
      end
    end
  end

  assign io_bus.issueblk_done = w_accept;
  assign io_bus.cdb_req       = w_cdb_req;
  assign io_bus.CDB_valid     = w_cdb_vld;
  assign io_bus.CDB_tag       = r_cdb_tag;
  assign io_bus.CDB_data      = r_cdb_data;

endmodule

// File: tb/tb_int_issue_unit.sv
// Directed bench for int_issue_unit: handshake timing, grant stalls, MUL latency, back-to-back issue, reset flush.
module tb_int_issue_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  int_issue_unit_if #(.DATA_W(32), .TAG_W(6)) bus ();

  int_issue_unit #(.DATA_W(32), .TAG_W(6), .MUL_LAT(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef INT_ISSUE_MUL_EN
  localparam int MUL_VLD_CYC = 6;
  localparam logic [31:0] MUL_3X5 = 32'd15;
`else
  localparam int MUL_VLD_CYC = 3;
  localparam logic [31:0] MUL_3X5 = 32'd0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] op, input logic [5:0] tag, input logic [31:0] a, input logic [31:0] b);
    bus.issue_opcode   = op;
    bus.issue_rd_tag   = tag;
    bus.issue_rs1_data = a;
    bus.issue_rs2_data = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.issueque_ready = 1'b0;
    bus.cdb_grant = 1'b0;
    present(3'b000, 6'h00, 32'h0, 32'h0);
    step();
    step();
    checks++; if (bus.cdb_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.cdb_req); end
    checks++; if (bus.CDB_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.CDB_valid); end
    checks++; if (bus.CDB_tag !== 6'h00 || bus.CDB_data !== 32'h0) begin errors++; $display("FAIL reset_cdb: got tag %h data %h want 0/0", bus.CDB_tag, bus.CDB_data); end
    checks++; if (bus.issueblk_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.issueblk_done); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    bus.cdb_grant = 1'b1;
    present(3'b000, 6'h0A, 32'd5, 32'd7);
    bus.issueque_ready = 1'b1;
    #1;
    checks++; if (bus.issueblk_done !== 1'b1) begin errors++; $display("FAIL add_accept: got %b want 1", bus.issueblk_done); end
    step();
    bus.issueque_ready = 1'b0;
    #1;
    checks++; if (bus.cdb_req !== 1'b0 || bus.CDB_valid !== 1'b0) begin errors++; $display("FAIL add_c1: got req %b vld %b want 0/0", bus.cdb_req, bus.CDB_valid); end
    step();
    checks++; if (bus.cdb_req !== 1'b1) begin errors++; $display("FAIL add_c2_req: got %b want 1", bus.cdb_req); end
    step();
    checks++; if (bus.CDB_valid !== 1'b1 || bus.CDB_tag !== 6'h0A || bus.CDB_data !== 32'd12) begin
      errors++; $display("FAIL add_c3_bcast: got vld %b tag %h data %h want 1/0a/0000000c", bus.CDB_valid, bus.CDB_tag, bus.CDB_data); end
    step();
    checks++; if (bus.CDB_valid !== 1'b0 || bus.CDB_data !== 32'd12) begin errors++; $display("FAIL add_c4: got vld %b data %h want 0/0000000c", bus.CDB_valid, bus.CDB_data); end
  endtask

  task automatic test_sub_grant_delay();
    int req_cyc;
    int done_cyc;
    int vld_cyc;
    req_cyc = 0; done_cyc = 0; vld_cyc = 0;
    bus.cdb_grant = 1'b0;
    present(3'b001, 6'h3F, 32'd0, 32'd1);
    bus.issueque_ready = 1'b1;
    #1;
    checks++; if (bus.issueblk_done !== 1'b1) begin errors++; $display("FAIL sub_accept: got %b want 1", bus.issueblk_done); end
    for (int c = 1; c <= 6; c++) begin
      step();
      bus.cdb_grant = (c == 6);
      #1;
      if (bus.cdb_req === 1'b1) req_cyc++;
      if (bus.issueblk_done === 1'b1) done_cyc++;
      if (bus.CDB_valid === 1'b1) vld_cyc++;
    end
    step();
    bus.issueque_ready = 1'b0;
    bus.cdb_grant = 1'b0;
    #1;
    checks++; if (req_cyc !== 5) begin errors++; $display("FAIL sub_req_hold: got %0d cycles want 5", req_cyc); end
    checks++; if (done_cyc !== 0 || vld_cyc !== 0) begin errors++; $display("FAIL sub_stall: got done %0d vld %0d cycles want 0/0", done_cyc, vld_cyc); end
    checks++; if (bus.CDB_valid !== 1'b1 || bus.CDB_tag !== 6'h3F || bus.CDB_data !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sub_bcast: got vld %b tag %h data %h want 1/3f/ffffffff", bus.CDB_valid, bus.CDB_tag, bus.CDB_data); end
    step();
    checks++; if (bus.CDB_valid !== 1'b0) begin errors++; $display("FAIL sub_pulse: got %b want 0", bus.CDB_valid); end
  endtask

  task automatic run_mul(input string name, input logic [5:0] tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int first;
    int cnt;
    logic [31:0] dat;
    logic [5:0]  tg;
    first = -1; cnt = 0; dat = 32'hDEAD_BEEF; tg = 6'h00;
    bus.cdb_grant = 1'b1;
    present(3'b111, tag, a, b);
    bus.issueque_ready = 1'b1;
    #1;
    checks++; if (bus.issueblk_done !== 1'b1) begin errors++; $display("FAIL %s_accept: got %b want 1", name, bus.issueblk_done); end
    for (int c = 1; c <= 10; c++) begin
      step();
      bus.issueque_ready = 1'b0;
      #1;
      if (bus.CDB_valid === 1'b1) begin
        cnt++;
        if (first < 0) begin first = c; dat = bus.CDB_data; tg = bus.CDB_tag; end
      end
    end
    checks++; if (first !== MUL_VLD_CYC || cnt !== 1) begin errors++; $display("FAIL %s_latency: got first %0d count %0d want %0d/1", name, first, cnt, MUL_VLD_CYC); end
    checks++; if (dat !== exp || tg !== tag) begin errors++; $display("FAIL %s_result: got data %h tag %h want %h/%h", name, dat, tg, exp, tag); end
  endtask

  task automatic test_mul();
    run_mul("mul_hi", 6'h21, 32'h0001_0000, 32'h0001_0000, 32'h0);
    run_mul("mul_3x5", 6'h22, 32'd3, 32'd5, MUL_3X5);
  endtask

  task automatic test_back_to_back();
    bus.cdb_grant = 1'b1;
    present(3'b010, 6'h11, 32'h0000_F0F0, 32'h0000_FF00);
    bus.issueque_ready = 1'b1;
    #1;
    checks++; if (bus.issueblk_done !== 1'b1) begin errors++; $display("FAIL b2b_accept1: got %b want 1", bus.issueblk_done); end
    step();
    present(3'b101, 6'h12, 32'd1, 32'h21);
    #1;
    checks++; if (bus.issueblk_done !== 1'b0) begin errors++; $display("FAIL b2b_exec_done: got %b want 0", bus.issueblk_done); end
    step();
    step();
    checks++; if (bus.CDB_valid !== 1'b1 || bus.CDB_tag !== 6'h11 || bus.CDB_data !== 32'h0000_F000) begin
      errors++; $display("FAIL b2b_bcast1: got vld %b tag %h data %h want 1/11/0000f000", bus.CDB_valid, bus.CDB_tag, bus.CDB_data); end
    checks++; if (bus.issueblk_done !== 1'b1) begin errors++; $display("FAIL b2b_accept2: got %b want 1", bus.issueblk_done); end
    step();
    bus.issueque_ready = 1'b0;
    #1;
    checks++; if (bus.CDB_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b want 0", bus.CDB_valid); end
    step();
    step();
    checks++; if (bus.CDB_valid !== 1'b1 || bus.CDB_tag !== 6'h12 || bus.CDB_data !== 32'd2) begin
      errors++; $display("FAIL b2b_bcast2: got vld %b tag %h data %h want 1/12/00000002", bus.CDB_valid, bus.CDB_tag, bus.CDB_data); end
    step();
  endtask

  task automatic test_reset_in_req();
    int vld_cyc;
    vld_cyc = 0;
    bus.cdb_grant = 1'b0;
    present(3'b000, 6'h05, 32'd1, 32'd2);
    bus.issueque_ready = 1'b1;
    step();
    bus.issueque_ready = 1'b0;
    step();
    checks++; if (bus.cdb_req !== 1'b1) begin errors++; $display("FAIL rstreq_in_req: got %b want 1", bus.cdb_req); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.cdb_req !== 1'b0 || bus.CDB_valid !== 1'b0) begin errors++; $display("FAIL rstreq_ctl: got req %b vld %b want 0/0", bus.cdb_req, bus.CDB_valid); end
    checks++; if (bus.CDB_tag !== 6'h00 || bus.CDB_data !== 32'h0) begin errors++; $display("FAIL rstreq_cdb: got tag %h data %h want 00/00000000", bus.CDB_tag, bus.CDB_data); end
    bus.cdb_grant = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.CDB_valid === 1'b1) vld_cyc++;
    end
    checks++; if (vld_cyc !== 0) begin errors++; $display("FAIL rstreq_no_bcast: got %0d broadcasts want 0", vld_cyc); end
  endtask

  task automatic test_grant_ignored();
    int bad;
    bad = 0;
    bus.cdb_grant = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (bus.CDB_valid !== 1'b0 || bus.cdb_req !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL gnt_idle: got %0d active cycles want 0", bad); end
    bus.cdb_grant = 1'b0;
    present(3'b000, 6'h2A, 32'h100, 32'h23);
    bus.issueque_ready = 1'b1;
    step();
    bus.issueque_ready = 1'b0;
    bus.cdb_grant = 1'b1;
    step();
    bus.cdb_grant = 1'b0;
    #1;
    checks++; if (bus.cdb_req !== 1'b1 || bus.CDB_valid !== 1'b0) begin errors++; $display("FAIL gnt_exec_c2: got req %b vld %b want 1/0", bus.cdb_req, bus.CDB_valid); end
    step();
    checks++; if (bus.cdb_req !== 1'b1 || bus.CDB_valid !== 1'b0) begin errors++; $display("FAIL gnt_exec_c3: got req %b vld %b want 1/0", bus.cdb_req, bus.CDB_valid); end
    bus.cdb_grant = 1'b1;
    step();
    bus.cdb_grant = 1'b0;
    checks++; if (bus.CDB_valid !== 1'b1 || bus.CDB_tag !== 6'h2A || bus.CDB_data !== 32'h123) begin
      errors++; $display("FAIL gnt_bcast: got vld %b tag %h data %h want 1/2a/00000123", bus.CDB_valid, bus.CDB_tag, bus.CDB_data); end
    step();
    checks++; if (bus.CDB_valid !== 1'b0) begin errors++; $display("FAIL gnt_pulse: got %b want 0", bus.CDB_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub_grant_delay();
    test_mul();
    test_back_to_back();
    test_reset_in_req();
    test_grant_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
